// File: rtl/cr_crcgc_stats_acc_if.sv
// Purpose: event, config, read-port and status bundle of the CRC stats accumulator.
// Latency: none (signal bundle only).
// Backpressure: none; the master may issue a read request every cycle.
interface cr_crcgc_stats_acc_if #(
  parameter int N_EVENTS  = 8,
  parameter int CNT_WIDTH = 32
);
  localparam int AW = $clog2(N_EVENTS);

  logic [N_EVENTS-1:0]  stat_events;
  logic                 freeze;
  logic                 clr_on_rd;
  logic                 snap_req;
  logic                 rd_req;
  logic                 rd_snap;
  logic [AW-1:0]        rd_addr;
  logic                 rd_ack;
  logic [CNT_WIDTH-1:0] rd_data;
  logic [N_EVENTS-1:0]  sat_flags;
  logic                 err_irq;
  logic                 irq_clr;

  // Register block / event source side
  modport master (
    output stat_events, freeze, clr_on_rd, snap_req, rd_req, rd_snap, rd_addr, irq_clr,
    input  rd_ack, rd_data, sat_flags, err_irq
  );

  // Accumulator side
  modport slave (
    input  stat_events, freeze, clr_on_rd, snap_req, rd_req, rd_snap, rd_addr, irq_clr,
    output rd_ack, rd_data, sat_flags, err_irq
  );
endinterface

// File: rtl/cr_crcgc_stats_acc.sv
// Purpose: saturating per-event counters with snapshot bank, sticky sat flags and error irq.
// Latency: events visible in live counters next cycle; read data/ack one cycle after rd_req.
// Backpressure: none; a read is accepted every cycle and always acked on the following cycle.
module cr_crcgc_stats_acc #(
  parameter int N_EVENTS  = 8,
  parameter int CNT_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  cr_crcgc_stats_acc_if.slave io_bus
);

  localparam int AW = $clog2(N_EVENTS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [N_EVENTS-1:0]  w_inc;
  logic [N_EVENTS-1:0]  w_sat_hit;
  logic [N_EVENTS-1:0]  w_clr;
  logic [N_EVENTS-1:0]  w_err_mask;
  logic                 w_live_rd;
  logic [CNT_WIDTH-1:0] w_rd_val;
  logic [CNT_WIDTH-1:0] w_nxt  [N_EVENTS];

  logic [CNT_WIDTH-1:0] r_live [N_EVENTS];
  logic [CNT_WIDTH-1:0] r_snap [N_EVENTS];
  logic [N_EVENTS-1:0]  r_sat;
  logic                 r_err_irq;
  logic                 r_rd_ack;
  logic [CNT_WIDTH-1:0] r_rd_data;

  // Next counter values, clear decisions and read mux. The live read returns the
  // post-event value so a same-cycle event is reported even when the read clears it.
  // Out-of-range addresses match no counter and therefore return 0.
  always_comb begin
    w_inc     = io_bus.stat_events & ~{N_EVENTS{io_bus.freeze}};
    w_live_rd = io_bus.rd_req & ~io_bus.rd_snap;
    w_rd_val  = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      w_err_mask[i] = (i % 2) == 1;
      w_sat_hit[i]  = (r_live[i] == CNT_MAX) & w_inc[i];
      w_nxt[i]      = (r_live[i] == CNT_MAX) ? r_live[i] : r_live[i] + CNT_WIDTH'(w_inc[i]);
      w_clr[i]      = io_bus.snap_req |
                      (w_live_rd & io_bus.clr_on_rd & (io_bus.rd_addr == AW'(i)));
      if (io_bus.rd_addr == AW'(i)) begin
        w_rd_val = io_bus.rd_snap ? r_snap[i] : w_nxt[i];
      end
    end
  end

  // Live counters: count every cycle, cleared by snapshot or clear-on-read
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (rst)           r_live[i] <= '0;
      else if (w_clr[i]) r_live[i] <= '0;
      else               r_live[i] <= w_nxt[i];
    end
  end

  // Snapshot bank: captures the post-event values so no same-cycle event is lost
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (rst)                  r_snap[i] <= '0;
      else if (io_bus.snap_req) r_snap[i] <= w_nxt[i];
    end
  end

  // Sticky saturation flags, dropped together with their counter
  always_ff @(posedge clk) begin
    if (rst) r_sat <= '0;
    else     r_sat <= (r_sat | w_sat_hit) & ~w_clr;
  end

  // Error interrupt: odd-index events set it, set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)                          r_err_irq <= 1'b0;
    else if (|(w_inc & w_err_mask))   r_err_irq <= 1'b1;
    else if (io_bus.irq_clr)          r_err_irq <= 1'b0;
  end

  // Read port: one-cycle ack, data held between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_ack <= io_bus.rd_req;
      if (io_bus.rd_req) r_rd_data <= w_rd_val;
    end
  end

  assign io_bus.rd_ack    = r_rd_ack;
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.sat_flags = r_sat;
  assign io_bus.err_irq   = r_err_irq;

endmodule

// File: tb/tb_cr_crcgc_stats_acc.sv
// Purpose: directed self-checking bench for the CRC stats accumulator (4-bit counters).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_cr_crcgc_stats_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cr_crcgc_stats_acc_if #(.N_EVENTS(8), .CNT_WIDTH(4)) bus ();
  cr_crcgc_stats_acc_if #(.N_EVENTS(6), .CNT_WIDTH(4)) bus6 ();

  cr_crcgc_stats_acc #(.N_EVENTS(8), .CNT_WIDTH(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  // Non-power-of-two instance so out-of-range addresses can be driven
  cr_crcgc_stats_acc #(.N_EVENTS(6), .CNT_WIDTH(4)) u_dut6 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus6.slave)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus on the 8-event instance
  task automatic cyc(input logic [7:0] ev, input logic snap, input logic rd,
                     input logic rs, input logic [2:0] addr);
    bus.stat_events = ev;
    bus.snap_req    = snap;
    bus.rd_req      = rd;
    bus.rd_snap     = rs;
    bus.rd_addr     = addr;
    @(negedge clk);
    bus.stat_events = '0;
    bus.snap_req    = 1'b0;
    bus.rd_req      = 1'b0;
    bus.rd_snap     = 1'b0;
    bus.rd_addr     = '0;
  endtask

  task automatic pulse(input logic [7:0] ev, input int n);
    for (int k = 0; k < n; k++) cyc(ev, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic rd_chk(input string tag, input logic rs, input logic [2:0] addr,
                        input logic [3:0] exp);
    cyc(8'h00, 1'b0, 1'b1, rs, addr);
    chk({tag, "_ack"}, 32'(bus.rd_ack), 32'd1);
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic rd6_chk(input string tag, input logic [2:0] addr, input logic [3:0] exp);
    bus6.rd_req  = 1'b1;
    bus6.rd_addr = addr;
    @(negedge clk);
    bus6.rd_req  = 1'b0;
    bus6.rd_addr = '0;
    chk({tag, "_ack"}, 32'(bus6.rd_ack), 32'd1);
    chk(tag, 32'(bus6.rd_data), 32'(exp));
  endtask

  initial begin
    bus.stat_events = '0; bus.freeze = 1'b0; bus.clr_on_rd = 1'b0; bus.snap_req = 1'b0;
    bus.rd_req = 1'b0; bus.rd_snap = 1'b0; bus.rd_addr = '0; bus.irq_clr = 1'b0;
    bus6.stat_events = '0; bus6.freeze = 1'b0; bus6.clr_on_rd = 1'b0; bus6.snap_req = 1'b0;
    bus6.rd_req = 1'b0; bus6.rd_snap = 1'b0; bus6.rd_addr = '0; bus6.irq_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack",  32'(bus.rd_ack),    32'd0);
    chk("rst_data", 32'(bus.rd_data),   32'd0);
    chk("rst_sat",  32'(bus.sat_flags), 32'd0);
    chk("rst_irq",  32'(bus.err_irq),   32'd0);
    rst = 1'b0;

    // Basic count: 3 pulses on bits 0 and 2
    pulse(8'h05, 3);
    chk("basic_irq", 32'(bus.err_irq), 32'd0);
    rd_chk("basic_rd1", 1'b0, 3'd1, 4'd0);
    rd_chk("basic_rd0", 1'b0, 3'd0, 4'd3);
    rd_chk("basic_rd2", 1'b0, 3'd2, 4'd3);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("ack_fall",  32'(bus.rd_ack),  32'd0);
    chk("data_hold", 32'(bus.rd_data), 32'd3);

    // Same-cycle read and clear on counter 3
    pulse(8'h08, 10);
    chk("irq_set", 32'(bus.err_irq), 32'd1);
    bus.irq_clr = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.irq_clr = 1'b0;
    chk("irq_clr", 32'(bus.err_irq), 32'd0);
    bus.clr_on_rd = 1'b1;
    cyc(8'h08, 1'b0, 1'b1, 1'b0, 3'd3);
    chk("rdclr_ack",  32'(bus.rd_ack),  32'd1);
    chk("rdclr_data", 32'(bus.rd_data), 32'd11);
    chk("rdclr_irq",  32'(bus.err_irq), 32'd1);
    rd_chk("rdclr_after", 1'b0, 3'd3, 4'd0);
    bus.clr_on_rd = 1'b0;

    // Saturation on bit 6, plus live[0] raised to 5 for the snapshot
    pulse(8'h40, 15);
    chk("sat_edge", 32'(bus.sat_flags), 32'h00);
    pulse(8'h40, 2);
    chk("sat_set", 32'(bus.sat_flags), 32'h40);
    rd_chk("sat_live", 1'b0, 3'd6, 4'd15);
    pulse(8'h01, 2);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("sat_snapclr", 32'(bus.sat_flags), 32'h00);
    rd_chk("sat_snap6",  1'b1, 3'd6, 4'd15);
    rd_chk("sat_live6",  1'b0, 3'd6, 4'd0);
    rd_chk("snap2",      1'b1, 3'd2, 4'd3);

    // Snapshot atomicity: snapshot read during snap_req sees the old bank
    pulse(8'h01, 5);
    cyc(8'h01, 1'b1, 1'b1, 1'b1, 3'd0);
    chk("atom_old", 32'(bus.rd_data), 32'd5);
    rd_chk("atom_new",  1'b1, 3'd0, 4'd6);
    rd_chk("atom_live", 1'b0, 3'd0, 4'd0);

    // Snapshot plus clearing live read in the same cycle
    pulse(8'h04, 4);
    bus.clr_on_rd = 1'b1;
    cyc(8'h04, 1'b1, 1'b1, 1'b0, 3'd2);
    bus.clr_on_rd = 1'b0;
    chk("snaprd_data", 32'(bus.rd_data), 32'd5);
    rd_chk("snaprd_snap", 1'b1, 3'd2, 4'd5);
    rd_chk("snaprd_live", 1'b0, 3'd2, 4'd0);

    // Freeze blocks counting and irq set; set wins over same-cycle clear
    bus.irq_clr = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.irq_clr = 1'b0;
    bus.freeze = 1'b1;
    pulse(8'hFF, 4);
    chk("frz_irq", 32'(bus.err_irq), 32'd0);
    cyc(8'hFF, 1'b0, 1'b1, 1'b0, 3'd5);
    chk("frz_rd5", 32'(bus.rd_data), 32'd0);
    rd_chk("frz_rd7", 1'b0, 3'd7, 4'd0);
    bus.freeze = 1'b0;
    bus.irq_clr = 1'b1;
    cyc(8'h02, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("race_irq", 32'(bus.err_irq), 32'd1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.irq_clr = 1'b0;
    chk("irq_fall", 32'(bus.err_irq), 32'd0);
    rd_chk("race_rd1", 1'b0, 3'd1, 4'd1);

    // Reset with a concurrent read request
    rst = 1'b1;
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 3'd1);
    rst = 1'b0;
    chk("rstrd_ack",  32'(bus.rd_ack),  32'd0);
    chk("rstrd_data", 32'(bus.rd_data), 32'd0);
    rd_chk("rst_live1", 1'b0, 3'd1, 4'd0);
    rd_chk("rst_snap2", 1'b1, 3'd2, 4'd0);
    rd_chk("rst_snap0", 1'b1, 3'd0, 4'd0);

    // Out-of-range addresses on the 6-counter instance
    bus6.stat_events = 6'h3F;
    repeat (2) @(negedge clk);
    bus6.stat_events = '0;
    rd6_chk("oor_rd5", 3'd5, 4'd2);
    rd6_chk("oor_rd6", 3'd6, 4'd0);
    rd6_chk("oor_rd7", 3'd7, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
